// File: rtl/glitch_pkg.sv
// Shared types and constants for the glitch filter: FSM state encoding,
// counter width and a saturating-increment helper.
package glitch_pkg;

    localparam int COUNT_W = 8;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        QUAL_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        QUAL_LOW    = 2'd3
    } glitch_state_t;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous raw input into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule

// File: rtl/glitch_filter.sv
// Debounce/glitch filter: a synchronized level must hold STABLE_CYCLES samples
// before out follows it; accepted edges pulse rise/fall and bump edge_count.
module glitch_filter
    import glitch_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a,
    input  logic               count_clr,
    output logic               out,
    output logic               rise,
    output logic               fall,
    output logic [COUNT_W-1:0] edge_count,
    output glitch_state_t      dbg_state
);

    localparam logic [COUNT_W-1:0] ONE_CNT  = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] LAST_CNT = COUNT_W'(STABLE_CYCLES - 1);

    logic                w_s2;
    logic                w_acc_rise;
    logic                w_acc_fall;
    glitch_state_t       r_state;
    logic [COUNT_W-1:0]  r_qual_cnt;
    logic                r_out;
    logic                r_rise;
    logic                r_fall;
    logic [COUNT_W-1:0]  r_edge_count;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (a),
        .q   (w_s2)
    );

    // r_qual_cnt holds the samples already seen in the new level; acceptance
    // happens on the sample that completes STABLE_CYCLES of them.
    always_comb begin
        w_acc_rise = 1'b0;
        w_acc_fall = 1'b0;
        case (r_state)
            STABLE_LOW:  w_acc_rise = w_s2 && (STABLE_CYCLES == 1);
            QUAL_HIGH:   w_acc_rise = w_s2 && (r_qual_cnt == LAST_CNT);
            STABLE_HIGH: w_acc_fall = !w_s2 && (STABLE_CYCLES == 1);
            QUAL_LOW:    w_acc_fall = !w_s2 && (r_qual_cnt == LAST_CNT);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= STABLE_LOW;
            r_qual_cnt <= '0;
            r_out      <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                STABLE_LOW: begin
                    if (w_acc_rise) begin
                        r_state <= STABLE_HIGH;
                        r_out   <= 1'b1;
                        r_rise  <= 1'b1;
                    end else if (w_s2) begin
                        r_state    <= QUAL_HIGH;
                        r_qual_cnt <= ONE_CNT;
                    end
                end
                QUAL_HIGH: begin
                    if (!w_s2) begin
                        r_state    <= STABLE_LOW;
                        r_qual_cnt <= '0;
                    end else if (w_acc_rise) begin
                        r_state    <= STABLE_HIGH;
                        r_out      <= 1'b1;
                        r_rise     <= 1'b1;
                        r_qual_cnt <= '0;
                    end else begin
                        r_qual_cnt <= r_qual_cnt + ONE_CNT;
                    end
                end
                STABLE_HIGH: begin
                    if (w_acc_fall) begin
                        r_state <= STABLE_LOW;
                        r_out   <= 1'b0;
                        r_fall  <= 1'b1;
                    end else if (!w_s2) begin
                        r_state    <= QUAL_LOW;
                        r_qual_cnt <= ONE_CNT;
                    end
                end
                QUAL_LOW: begin
                    if (w_s2) begin
                        r_state    <= STABLE_HIGH;
                        r_qual_cnt <= '0;
                    end else if (w_acc_fall) begin
                        r_state    <= STABLE_LOW;
                        r_out      <= 1'b0;
                        r_fall     <= 1'b1;
                        r_qual_cnt <= '0;
                    end else begin
                        r_qual_cnt <= r_qual_cnt + ONE_CNT;
                    end
                end
                default: begin
                    r_state    <= STABLE_LOW;
                    r_qual_cnt <= '0;
                end
            endcase
        end
    end

    // The count moves on the same edge that raises rise/fall; a clear wins.
    always_ff @(posedge clk) begin
        if (rst || count_clr) begin
            r_edge_count <= '0;
        end else if (w_acc_rise || w_acc_fall) begin
            r_edge_count <= sat_inc(r_edge_count);
        end
    end

    assign out        = r_out;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign edge_count = r_edge_count;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_glitch_filter.sv
// Directed bench for glitch_filter: one instance with STABLE_CYCLES=4 and one
// with STABLE_CYCLES=1, sharing clock and reset.
module tb_glitch_filter;
    import glitch_pkg::*;

    logic               clk;
    logic               rst;
    logic               a;
    logic               count_clr;
    logic               out;
    logic               rise;
    logic               fall;
    logic [COUNT_W-1:0] edge_count;
    glitch_state_t      dbg_state;

    logic               a1;
    logic               count_clr1;
    logic               out1;
    logic               rise1;
    logic               fall1;
    logic [COUNT_W-1:0] edge_count1;
    glitch_state_t      dbg_state1;

    int n_checks = 0;
    int n_errors = 0;

    glitch_filter #(.STABLE_CYCLES(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .count_clr  (count_clr),
        .out        (out),
        .rise       (rise),
        .fall       (fall),
        .edge_count (edge_count),
        .dbg_state  (dbg_state)
    );

    glitch_filter #(.STABLE_CYCLES(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .a          (a1),
        .count_clr  (count_clr1),
        .out        (out1),
        .rise       (rise1),
        .fall       (fall1),
        .edge_count (edge_count1),
        .dbg_state  (dbg_state1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change right after sampling, i.e. 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; a = 1'b1; a1 = 1'b1; count_clr = 1'b0; count_clr1 = 1'b0;
        tick(); tick();
        a = 1'b0; a1 = 1'b0;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({out, rise, fall, edge_count} !== 11'd0 || dbg_state !== STABLE_LOW) begin
            n_errors++;
            $display("FAIL reset_dut4 got out=%0b rise=%0b fall=%0b cnt=%0d st=%0d exp all zero",
                     out, rise, fall, edge_count, dbg_state);
        end
        n_checks++;
        if ({out1, rise1, fall1, edge_count1} !== 11'd0 || dbg_state1 !== STABLE_LOW) begin
            n_errors++;
            $display("FAIL reset_dut1 got out=%0b rise=%0b fall=%0b cnt=%0d st=%0d exp all zero",
                     out1, rise1, fall1, edge_count1, dbg_state1);
        end
    endtask

    task automatic test_idle();
        a = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_checks++;
            if ({out, rise, fall, edge_count} !== 11'd0) begin
                n_errors++;
                $display("FAIL idle k=%0d got out=%0b rise=%0b fall=%0b cnt=%0d exp 0,0,0,0",
                         k, out, rise, fall, edge_count);
            end
        end
    endtask

    // count_clr pulsed mid-qualification must not disturb the FSM.
    task automatic test_latency();
        logic exp_out, exp_rise, exp_fall;
        logic [7:0] exp_cnt;
        a = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            count_clr = (k == 3);
            tick();
            exp_out  = (k >= 6);
            exp_rise = (k == 6);
            exp_cnt  = (k >= 6) ? 8'd1 : 8'd0;
            n_checks++;
            if (out !== exp_out || rise !== exp_rise || fall !== 1'b0 || edge_count !== exp_cnt) begin
                n_errors++;
                $display("FAIL latency_rise k=%0d got out=%0b rise=%0b fall=%0b cnt=%0d exp %0b,%0b,0,%0d",
                         k, out, rise, fall, edge_count, exp_out, exp_rise, exp_cnt);
            end
        end
        count_clr = 1'b0;
        a = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_out  = (k < 6);
            exp_fall = (k == 6);
            exp_cnt  = (k >= 6) ? 8'd2 : 8'd1;
            n_checks++;
            if (out !== exp_out || fall !== exp_fall || rise !== 1'b0 || edge_count !== exp_cnt) begin
                n_errors++;
                $display("FAIL latency_fall k=%0d got out=%0b rise=%0b fall=%0b cnt=%0d exp %0b,0,%0b,%0d",
                         k, out, rise, fall, edge_count, exp_out, exp_fall, exp_cnt);
            end
        end
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        n_checks++;
        if (edge_count !== 8'd0 || out !== 1'b0) begin
            n_errors++;
            $display("FAIL count_clr got cnt=%0d out=%0b exp 0,0", edge_count, out);
        end
    endtask

    task automatic test_short_pulse();
        logic exp_out, exp_rise, exp_fall;
        a = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3) a = 1'b0;
            n_checks++;
            if ({out, rise, fall, edge_count} !== 11'd0) begin
                n_errors++;
                $display("FAIL pulse3 k=%0d got out=%0b rise=%0b fall=%0b cnt=%0d exp 0,0,0,0",
                         k, out, rise, fall, edge_count);
            end
        end
        n_checks++;
        if (dbg_state !== STABLE_LOW) begin
            n_errors++;
            $display("FAIL pulse3_state got %0d exp %0d", dbg_state, STABLE_LOW);
        end
        a = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 4) a = 1'b0;
            exp_out  = (k >= 6 && k < 10);
            exp_rise = (k == 6);
            exp_fall = (k == 10);
            n_checks++;
            if (out !== exp_out || rise !== exp_rise || fall !== exp_fall) begin
                n_errors++;
                $display("FAIL pulse4 k=%0d got out=%0b rise=%0b fall=%0b exp %0b,%0b,%0b",
                         k, out, rise, fall, exp_out, exp_rise, exp_fall);
            end
        end
        n_checks++;
        if (edge_count !== 8'd2) begin
            n_errors++;
            $display("FAIL pulse4_count got %0d exp 2", edge_count);
        end
    endtask

    task automatic test_rst_mid_qual();
        logic exp_out, exp_rise;
        a = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (out !== 1'b0 || rise !== 1'b0 || edge_count !== 8'd0 || dbg_state !== STABLE_LOW) begin
            n_errors++;
            $display("FAIL rst_mid got out=%0b rise=%0b cnt=%0d st=%0d exp 0,0,0,%0d",
                     out, rise, edge_count, dbg_state, STABLE_LOW);
        end
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_out  = (k >= 6);
            exp_rise = (k == 6);
            n_checks++;
            if (out !== exp_out || rise !== exp_rise) begin
                n_errors++;
                $display("FAIL rst_requal k=%0d got out=%0b rise=%0b exp %0b,%0b",
                         k, out, rise, exp_out, exp_rise);
            end
        end
        a = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_saturation();
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        for (int t = 1; t <= 300; t++) begin
            a = ~a;
            repeat (10) tick();
            if (t == 254 || t == 255 || t == 300) begin
                n_checks++;
                if (edge_count !== ((t < 255) ? 8'(t) : 8'd255)) begin
                    n_errors++;
                    $display("FAIL sat t=%0d got %0d exp %0d", t, edge_count,
                             (t < 255) ? t : 255);
                end
            end
        end
        a = 1'b1;
        repeat (10) tick();
        n_checks++;
        if (edge_count !== 8'd255 || out !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_hold got cnt=%0d out=%0b exp 255,1", edge_count, out);
        end
        a = 1'b0;
        repeat (5) tick();
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        n_checks++;
        if (fall !== 1'b1 || edge_count !== 8'd0) begin
            n_errors++;
            $display("FAIL clr_vs_fall got fall=%0b cnt=%0d exp 1,0", fall, edge_count);
        end
        tick();
        n_checks++;
        if (fall !== 1'b0 || edge_count !== 8'd0 || out !== 1'b0) begin
            n_errors++;
            $display("FAIL clr_after got fall=%0b cnt=%0d out=%0b exp 0,0,0", fall, edge_count, out);
        end
    endtask

    task automatic test_stable1();
        logic exp_out, exp_rise, exp_fall;
        count_clr1 = 1'b1;
        tick();
        count_clr1 = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            a1 = ~a1;
            for (int k = 1; k <= 4; k++) begin
                tick();
                exp_out  = (k >= 3) ? a1 : ~a1;
                exp_rise = (k == 3) && a1;
                exp_fall = (k == 3) && !a1;
                n_checks++;
                if (out1 !== exp_out || rise1 !== exp_rise || fall1 !== exp_fall) begin
                    n_errors++;
                    $display("FAIL sc1 t=%0d k=%0d got out=%0b rise=%0b fall=%0b exp %0b,%0b,%0b",
                             t, k, out1, rise1, fall1, exp_out, exp_rise, exp_fall);
                end
            end
        end
        n_checks++;
        if (edge_count1 !== 8'd6) begin
            n_errors++;
            $display("FAIL sc1_count got %0d exp 6", edge_count1);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_latency();
        test_short_pulse();
        test_rst_mid_qual();
        test_saturation();
        test_stable1();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
